// File: rtl/rr_grant_ctrl_16.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_ctrl_16
// Brief    : 16-way round-robin grant controller (one-hot grant + index).
//            Optional hold timeout enabled by RR_GRANT_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module rr_grant_ctrl_16 #(
  parameter int N_REQ    = 16,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             release_i,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld,
  output logic             busy
`ifdef RR_GRANT_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [N_REQ-1:0]   r_grant;
  logic [IDX_W-1:0]   r_grant_idx;
  logic               r_grant_vld;
  logic               r_busy;

  logic               w_found;
  logic [IDX_W-1:0]   w_sel;
  logic [IDX_W-1:0]   w_cand;
  logic               w_release;
  logic               w_end;

  if (N_REQ != (1 << IDX_W) || MAX_HOLD >= (1 << IDX_W)) begin : g_param_check
    $error("rr_grant_ctrl_16: inconsistent N_REQ/IDX_W/MAX_HOLD");
  end

  // First requester at or above the pointer; the index adder wraps 15->0.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_cand = r_ptr + IDX_W'(i);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  assign w_release = release_i | ~req[r_grant_idx];

`ifdef RR_GRANT_TIMEOUT_EN
  logic [IDX_W-1:0] r_hold;
  logic             w_force;

  // A normal release in the same cycle wins, so the force term excludes it.
  assign w_force = (r_hold == IDX_W'(MAX_HOLD)) & ~w_release;
  assign w_end   = w_release | w_force;
  assign timeout = r_busy & w_force;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (r_state == ST_IDLE) begin
      r_hold <= '0;
    end else if (!w_end) begin
      r_hold <= r_hold + 1'b1;
    end
  end
`else
  assign w_end = w_release;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_grant_vld <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en && w_found) begin
            r_state     <= ST_GRANT;
            r_grant     <= N_REQ'(1) << w_sel;
            r_grant_idx <= w_sel;
            r_grant_vld <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (w_end) begin
            r_state     <= ST_IDLE;
            r_ptr       <= r_grant_idx + 1'b1;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_grant_vld <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant     = r_grant;
  assign grant_idx = r_grant_idx;
  assign grant_vld = r_grant_vld;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_ctrl_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_grant_ctrl_16
// Brief    : Self-checking bench for rr_grant_ctrl_16 (behavioural model +
//            directed literal checks).
// Revision : 1.0
// ============================================================================
module tb_rr_grant_ctrl_16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [15:0] req = '0;
  logic        release_i = 1'b0;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_vld;
  logic        busy;
`ifdef RR_GRANT_TIMEOUT_EN
  logic        timeout;
`endif

  int total = 0;
  int bad   = 0;

  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;

  rr_grant_ctrl_16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .release_i (release_i),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld),
    .busy      (busy)
`ifdef RR_GRANT_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the resource, and where the next scan starts.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
    end else if (m_owner < 0) begin
      if (en && req != 16'h0) begin
        for (int i = 0; i < 16; i++) begin
          if (m_owner < 0 && req[(m_ptr + i) % 16]) m_owner = (m_ptr + i) % 16;
        end
        m_hold = 0;
      end
    end else begin
      bit rel;
      bit forced;
      rel    = release_i || !req[m_owner];
      forced = 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
      forced = !rel && (m_hold == 15);
`endif
      if (rel || forced) begin
        m_ptr   = (m_owner + 1) % 16;
        m_owner = -1;
      end else begin
        m_hold++;
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] exp_g;
    exp_g = (m_owner < 0) ? 16'h0 : (16'h1 << m_owner);
    chk("model_grant", 32'(grant), 32'(exp_g));
    chk("model_idx",   32'(grant_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk("model_vld",   32'(grant_vld), 32'(m_owner >= 0));
    chk("model_busy",  32'(busy), 32'(m_owner >= 0));
    chk("inv_onehot0", 32'($onehot0(grant)), 32'd1);
    chk("inv_vld_or",  32'(grant_vld), 32'(|grant));
`ifdef RR_GRANT_TIMEOUT_EN
    chk("model_timeout", 32'(timeout),
        32'((m_owner >= 0) && (m_hold == 15) && !(release_i || !req[m_owner])));
`endif
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_grant(input string nm, input logic [15:0] g, input logic [3:0] idx);
    chk({nm, "_grant"}, 32'(grant), 32'(g));
    chk({nm, "_idx"},   32'(grant_idx), 32'(idx));
  endtask

  initial begin
    en = 1'b1; req = 16'hFFFF;
    #1 rst_n = 1'b0;
    tick(2);
    chk_grant("reset", 16'h0000, 4'd0);
    chk("reset_vld",  32'(grant_vld), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_grant("first", 16'h0001, 4'd0);
    release_i = 1'b1; tick();
    chk_grant("dead", 16'h0000, 4'd0);
    release_i = 1'b0; tick();
    chk_grant("second", 16'h0002, 4'd1);

    // Pointer wrap across 15 -> 0.
    release_i = 1'b1; tick();
    release_i = 1'b0; req = 16'h8001; tick();
    chk_grant("wrap15", 16'h8000, 4'd15);
    release_i = 1'b1; tick();
    release_i = 1'b0; tick();
    chk_grant("wrap0", 16'h0001, 4'd0);
    release_i = 1'b1; tick();
    release_i = 1'b0; tick();
    chk_grant("wrap15b", 16'h8000, 4'd15);
    release_i = 1'b1; tick();
    release_i = 1'b0;

    // Owner withdraws; other bits ignored while granted.
    req = 16'h0010; tick();
    chk_grant("own4", 16'h0010, 4'd4);
    req = 16'hFFF0; tick();
    chk_grant("ignore_a", 16'h0010, 4'd4);
    req = 16'h001F; tick();
    chk_grant("ignore_b", 16'h0010, 4'd4);
    req = 16'h0000; tick();
    chk_grant("withdraw", 16'h0000, 4'd0);
    chk("withdraw_busy", 32'(busy), 32'd0);

    // Enable gates only new grants.
    en = 1'b0; req = 16'h0F00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_grant("en_off", 16'h0000, 4'd0);
    end
    en = 1'b1; tick();
    chk_grant("en_on", 16'h0100, 4'd8);
    en = 1'b0; tick();
    chk_grant("en_drop_a", 16'h0100, 4'd8);
    tick();
    chk_grant("en_drop_b", 16'h0100, 4'd8);
    release_i = 1'b1; tick();
    chk_grant("en_rel", 16'h0000, 4'd0);
    release_i = 1'b0; en = 1'b1;

    // Asynchronous reset during a grant.
    req = 16'h0400; tick();
    chk_grant("pre_rst", 16'h0400, 4'd10);
    #1 rst_n = 1'b0;
    #1;
    chk_grant("async_rst", 16'h0000, 4'd0);
    chk("async_rst_vld",  32'(grant_vld), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1; tick();
    chk_grant("post_rst", 16'h0400, 4'd10);

    // Fairness sweep with every requester active and immediate release.
    req = 16'hFFFF; release_i = 1'b1;
    tick(2);
    chk_grant("fair_start", 16'h0800, 4'd11);
    tick(30);
    chk_grant("fair_end", 16'h0400, 4'd10);
    release_i = 1'b0; req = 16'h0000;
    tick(2);

`ifdef RR_GRANT_TIMEOUT_EN
    req = 16'h0008; tick();
    chk_grant("to_start", 16'h0008, 4'd3);
    req = 16'h0028;
    tick(14);
    chk("to_early", 32'(timeout), 32'd0);
    tick();
    chk("to_pulse", 32'(timeout), 32'd1);
    chk_grant("to_hold", 16'h0008, 4'd3);
    tick();
    chk("to_clear", 32'(timeout), 32'd0);
    chk_grant("to_dead", 16'h0000, 4'd0);
    tick();
    chk_grant("to_next", 16'h0020, 4'd5);
    req = 16'h0000; tick(2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_grant_ctrl_16.md
Name: rr_grant_ctrl_16

Overview:
- Round-robin scheduler that shares one 16-way resource between 16 requesters.
- Emits the winner as a one-hot 16-bit grant (decoder side) and as a 4-bit index (encoder side), so the downstream 4-to-16 decoder and 16-to-4 encoder stay consistent.
- Sits between the requester bank and the shared datapath. Owns grant sequencing, hold and release.

Parameters:
- N_REQ, 16, number of requesters; fixed at 16 for this revision.
- IDX_W, 4, width of the grant index; log2(N_REQ).
- MAX_HOLD, 15, maximum grant length in cycles; used only with the optional feature.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  arbitration enable; gates new grants only
- req  input  16  request vector; bit k = requester k
- release_i  input  1  current owner finishes; sampled only in GRANT
- grant  output  16  one-hot grant, registered; all-zero when idle
- grant_idx  output  4  binary index of the grant bit; 0 when idle
- grant_vld  output  1  high while grant is non-zero
- busy  output  1  high in GRANT state
- timeout  output  1  one-cycle pulse on forced release; present only with the optional feature

Behaviour:
- Reset, while rst_n=0, asynchronously:
  - grant=0, grant_idx=0, grant_vld=0, busy=0, timeout=0
  - rotate pointer ptr=0, state=IDLE
- FSM states: IDLE, GRANT.
- IDLE:
  - If en=1 and req!=0, select the first set req bit scanning upward from ptr, wrapping 15->0.
  - Next edge: state=GRANT, grant=1<<k, grant_idx=k, grant_vld=1, busy=1.
  - Latency: req asserted at edge n gives grant visible after edge n+1.
  - If en=0 or req=0, stay in IDLE with outputs at zero.
- GRANT:
  - Grant holds unchanged.
  - Other req bits are ignored.
  - en=0 does not revoke an active grant.
- Release condition: release_i=1, or req[grant_idx]=0 (owner withdrew). Both at once count as a single release.
- On release, next edge:
  - state=IDLE, grant=0, grant_idx=0, grant_vld=0, busy=0
  - ptr=(grant_idx+1) mod 16; 15 wraps to 0
- Exactly one dead cycle (IDLE) separates consecutive grants. This applies even when the same or another requester is waiting.
- Fairness: with all 16 requesting and immediate release, winners follow k, k+1, ... 15, 0, ... Every requester is served within 16 grants.
- Invariants, checked every cycle:
  - grant is zero or one-hot.
  - grant_vld == |grant.
  - grant == (grant_vld ? 1<<grant_idx : 0).
- Reset mid-GRANT: all outputs clear immediately and ptr returns to 0. The first grant after reset scans from bit 0.
- release_i in IDLE is ignored.

Optional Feature:
- Macro: RR_GRANT_TIMEOUT_EN.
- Defined:
  - A hold counter (width IDX_W) clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD with no release, a forced release follows next edge. This release is identical to a normal one, including the ptr advance.
  - timeout pulses high for exactly that one cycle.
  - A normal release in the same cycle takes precedence, and timeout stays 0.
- Undefined: no counter and no timeout port. A grant lasts until release.

Test Plan:
- Reset with req=16'hFFFF, then release rst_n with en=1 -> edge 1 grant=16'h0001, grant_idx=0. Release -> dead cycle -> grant=16'h0002, idx=1.
- req=16'h8001, owner 15 granted then released -> next grant=16'h0001, idx=0 (pointer wrap). Then release -> next grant=16'h8000.
- req=16'h0010 granted. Drop req[4] with release_i=0 -> grant=0, busy=0 next edge. Other req bits toggling during the grant leave grant unchanged.
- en=0 with req=16'h0F00 -> no grant for 5 cycles. Raise en -> grant=16'h0100 one edge later. Drop en during the grant -> grant held until release_i.
- Assert rst_n=0 mid-grant (grant=16'h0400) -> grant, grant_idx, grant_vld and busy read 0 before the next clk edge. After reset, req=16'h0400 -> idx=10.
- With RR_GRANT_TIMEOUT_EN and MAX_HOLD=15: hold req[3] with no release -> timeout=1 for one cycle at the 16th GRANT cycle, then grant=0. A second requester at bit 5 is granted after the dead cycle.
